video_sync_generator: RTL and testbench

//  Downstream stage of the pixel/line counter pair (counter_with_preset, dir=0).

---
 rtl/video_sync_generator.sv | 149 ++++++++++++++
 tb/tb_video_sync_generator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_sync_generator.sv
// Sync/DE/coordinate generator fed by the pixel and line counters. Two region FSMs
// follow the counts, resynchronise on disagreement and raise a sticky desync flag.
module video_sync_generator #(
  parameter int   HBITS    = 10,
  parameter int   VBITS    = 10,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             c,
  input  logic             clr,
  input  logic             en,
  input  logic [HBITS-1:0] hcount,
  input  logic [VBITS-1:0] vcount,
  input  logic             hovf,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [HBITS-1:0] x,
  output logic [VBITS-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic             desync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << HBITS)) begin : g_hchk
    $error("H_TOTAL does not fit in HBITS");
  end
  if (V_TOTAL > (1 << VBITS)) begin : g_vchk
    $error("V_TOTAL does not fit in VBITS");
  end

  // Region start boundaries; anything at or beyond the sync end is back porch.
  localparam logic [HBITS-1:0] HA     = HBITS'(H_ACTIVE);
  localparam logic [HBITS-1:0] HS     = HBITS'(H_ACTIVE + H_FP);
  localparam logic [HBITS-1:0] HB     = HBITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VBITS-1:0] VA     = VBITS'(V_ACTIVE);
  localparam logic [VBITS-1:0] VS     = VBITS'(V_ACTIVE + V_FP);
  localparam logic [VBITS-1:0] VB     = VBITS'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VBITS-1:0] V_LAST = VBITS'(V_TOTAL - 1);

  typedef enum logic [1:0] {ACT, FRONT, SYNC, BACK} region_t;

  function automatic region_t hdecode(input logic [HBITS-1:0] cnt);
    if (cnt < HA)      return ACT;
    else if (cnt < HS) return FRONT;
    else if (cnt < HB) return SYNC;
    else               return BACK;
  endfunction

  function automatic region_t vdecode(input logic [VBITS-1:0] cnt);
    if (cnt < VA)      return ACT;
    else if (cnt < VS) return FRONT;
    else if (cnt < VB) return SYNC;
    else               return BACK;
  endfunction

  function automatic region_t hstep(input region_t s, input logic [HBITS-1:0] cnt);
    case (s)
      ACT:     return (cnt == HA) ? FRONT : ACT;
      FRONT:   return (cnt == HS) ? SYNC : FRONT;
      SYNC:    return (cnt == HB) ? BACK : SYNC;
      default: return (cnt == '0) ? ACT : BACK;
    endcase
  endfunction

  function automatic region_t vstep(input region_t s, input logic [VBITS-1:0] cnt);
    case (s)
      ACT:     return (cnt == VA) ? FRONT : ACT;
      FRONT:   return (cnt == VS) ? SYNC : FRONT;
      SYNC:    return (cnt == VB) ? BACK : SYNC;
      default: return (cnt == '0) ? ACT : BACK;
    endcase
  endfunction

  region_t          hstate, vstate;
  region_t          h_fsm, h_nxt, v_fsm, v_nxt;
  logic [VBITS-1:0] v_tgt;
  logic             mism;
  logic             de_nxt;

  always_ff @(posedge c) begin
    if (clr) begin
      hstate <= ACT;
      vstate <= ACT;
    end else if (en) begin
      hstate <= h_nxt;
      vstate <= v_nxt;
    end
  end

  // The line counter moves on hovf, so the vertical target is the count it is about
  // to load; out-of-range counts stay out of range and decode as back porch.
  always_comb begin
    v_tgt = vcount;
    if (vcount == V_LAST)
      v_tgt = '0;
    else if (vcount < V_LAST)
      v_tgt = vcount + VBITS'(1);

    h_fsm = hstep(hstate, hcount);
    h_nxt = hdecode(hcount);
    v_fsm = vstate;
    v_nxt = vdecode(vcount);
    if (hovf) begin
      v_fsm = vstep(vstate, v_tgt);
      v_nxt = vdecode(v_tgt);
    end
    mism   = (h_fsm != h_nxt) || (v_fsm != v_nxt);
    de_nxt = (h_nxt == ACT) && (v_nxt == ACT);
  end

  // Output register stage: one clock behind the sampled counts.
  always_ff @(posedge c) begin
    if (clr) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      desync      <= 1'b0;
    end else if (en) begin
      hsync       <= (h_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
      de          <= de_nxt;
      x           <= de_nxt ? hcount : '0;
      y           <= de_nxt ? vcount : '0;
      line_start  <= (hcount == '0) && (v_nxt == ACT);
      frame_start <= (hcount == '0) && (vcount == '0);
      if (mism)
        desync <= 1'b1;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_sync_generator.sv
// Bench for video_sync_generator: directed vector table, frame-wrap sequence,
// randomized run against a region-table model, and a full frame on a small timing.
module tb_video_sync_generator;

  logic c = 1'b0;
  always #5 c = ~c;

  logic       clr = 1'b0, en = 1'b0, hovf = 1'b0;
  logic [9:0] hc = '0, vc = '0;
  logic       hsync, vsync, de, line_start, frame_start, desync;
  logic [9:0] x, y;

  video_sync_generator dut (
    .c(c), .clr(clr), .en(en), .hcount(hc), .vcount(vc), .hovf(hovf),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .desync(desync)
  );

  logic       s_clr = 1'b0, s_en = 1'b0, s_hovf = 1'b0;
  logic [4:0] s_hc = '0;
  logic [3:0] s_vc = '0;
  logic       s_hsync, s_vsync, s_de, s_ls, s_fs, s_ds;
  logic [4:0] s_x;
  logic [3:0] s_y;

  video_sync_generator #(
    .HBITS(5), .VBITS(4), .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) dus (
    .c(c), .clr(s_clr), .en(s_en), .hcount(s_hc), .vcount(s_vc), .hovf(s_hovf),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .desync(s_ds)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      passed++;
  endtask

  // Reference model: regions from boundary tables of the 800x525 timing.
  int hstart[4] = '{0, 640, 656, 752};
  int vstart[4] = '{0, 480, 490, 492};
  int mh, mv, m_x, m_y;
  logic m_de, m_hs, m_vs, m_ls, m_fs, m_ds;

  function automatic int hreg_of(input int cnt);
    int r = 0;
    for (int k = 1; k < 4; k++) if (cnt >= hstart[k]) r = k;
    return r;
  endfunction

  function automatic int vreg_of(input int cnt);
    int r = 0;
    for (int k = 1; k < 4; k++) if (cnt >= vstart[k]) r = k;
    return r;
  endfunction

  task automatic ref_step(input logic k, input logic e, input int h, input int v, input logic o);
    int hd, hf, vd, vf, vt;
    if (k) begin
      mh = 0; mv = 0; m_de = 0; m_x = 0; m_y = 0;
      m_hs = 1; m_vs = 1; m_ls = 0; m_fs = 0; m_ds = 0;
    end else if (e) begin
      hd = hreg_of(h);
      hf = (h == hstart[(mh + 1) % 4]) ? (mh + 1) % 4 : mh;
      if (o) begin
        vt = (v == 524) ? 0 : ((v > 524) ? v : v + 1);
        vd = vreg_of(vt);
        vf = (vt == vstart[(mv + 1) % 4]) ? (mv + 1) % 4 : mv;
      end else begin
        vd = vreg_of(v);
        vf = mv;
      end
      if (hf != hd || vf != vd) m_ds = 1;
      mh = hd; mv = vd;
      m_de = (hd == 0) && (vd == 0);
      m_x  = m_de ? h : 0;
      m_y  = m_de ? v : 0;
      m_hs = (hd != 2);
      m_vs = (vd != 2);
      m_ls = (h == 0) && (vd == 0);
      m_fs = (h == 0) && (v == 0);
    end else begin
      m_ls = 0; m_fs = 0;
    end
  endtask

  task automatic cyc(input logic k, input logic e, input int h, input int v, input logic o);
    clr = k; en = e; hc = 10'(h); vc = 10'(v); hovf = o;
    @(posedge c); #1;
    ref_step(k, e, h, v, o);
  endtask

  task automatic walk_line(input int v);
    cyc(0, 1, 0, v, 0);
    cyc(0, 1, 640, v, 0);
    cyc(0, 1, 656, v, 0);
    cyc(0, 1, 752, v, 0);
    cyc(0, 1, 799, v, 1);
  endtask

  typedef struct {
    logic clr, en; int hc, vc; logic hovf;
    logic de; int x, y; logic hs, vs, ls, fs, ds;
  } vec_t;

  function automatic vec_t mk(input logic k, input logic e, input int h, input int v, input logic o,
                              input logic d, input int xx, input int yy,
                              input logic hs, input logic vs, input logic ls, input logic fs,
                              input logic ds);
    vec_t r;
    r.clr = k; r.en = e; r.hc = h; r.vc = v; r.hovf = o;
    r.de = d; r.x = xx; r.y = yy; r.hs = hs; r.vs = vs; r.ls = ls; r.fs = fs; r.ds = ds;
    return r;
  endfunction

  vec_t tbl[20];

  initial begin
    int h, v, n_de, n_hs, n_vs, n_ds;
    logic e, k, o;

    tbl[0]  = mk(1, 0,   0,   0, 0,  0,   0,   0, 1, 1, 0, 0, 0);
    tbl[1]  = mk(0, 1,   0,   0, 0,  1,   0,   0, 1, 1, 1, 1, 0);
    tbl[2]  = mk(0, 0,   1,   0, 0,  1,   0,   0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1,   1,   0, 0,  1,   1,   0, 1, 1, 0, 0, 0);
    tbl[4]  = mk(0, 1, 640,   0, 0,  0,   0,   0, 1, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 656,   0, 0,  0,   0,   0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 752,   0, 0,  0,   0,   0, 1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 799,   5, 1,  0,   0,   0, 1, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1,   0,   6, 0,  1,   0,   6, 1, 1, 1, 0, 0);
    tbl[9]  = mk(0, 1, 639,   6, 0,  1, 639,   6, 1, 1, 0, 0, 0);
    tbl[10] = mk(0, 1, 640,   6, 0,  0,   0,   0, 1, 1, 0, 0, 0);
    tbl[11] = mk(1, 0,   0,   0, 0,  0,   0,   0, 1, 1, 0, 0, 0);
    tbl[12] = mk(0, 1,   0,   0, 0,  1,   0,   0, 1, 1, 1, 1, 0);
    tbl[13] = mk(0, 1, 700,   0, 0,  0,   0,   0, 0, 1, 0, 0, 1);
    tbl[14] = mk(0, 1, 701,   0, 0,  0,   0,   0, 0, 1, 0, 0, 1);
    tbl[15] = mk(0, 1,   0,   0, 0,  1,   0,   0, 1, 1, 1, 1, 1);
    tbl[16] = mk(1, 0,   0,   0, 0,  0,   0,   0, 1, 1, 0, 0, 0);
    tbl[17] = mk(0, 1, 300, 200, 0,  1, 300, 200, 1, 1, 0, 0, 0);
    tbl[18] = mk(1, 1, 300, 200, 0,  0,   0,   0, 1, 1, 0, 0, 0);
    tbl[19] = mk(0, 1,   0,   0, 0,  1,   0,   0, 1, 1, 1, 1, 0);

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].clr, tbl[i].en, tbl[i].hc, tbl[i].vc, tbl[i].hovf);
      chk($sformatf("vec%0d.de", i),     de,          tbl[i].de);
      chk($sformatf("vec%0d.x", i),      x,           tbl[i].x);
      chk($sformatf("vec%0d.y", i),      y,           tbl[i].y);
      chk($sformatf("vec%0d.hsync", i),  hsync,       tbl[i].hs);
      chk($sformatf("vec%0d.vsync", i),  vsync,       tbl[i].vs);
      chk($sformatf("vec%0d.lstart", i), line_start,  tbl[i].ls);
      chk($sformatf("vec%0d.fstart", i), frame_start, tbl[i].fs);
      chk($sformatf("vec%0d.desync", i), desync,      tbl[i].ds);
    end

    // Frame wrap through the vertical porches and sync.
    cyc(1, 0, 0, 0, 0);
    walk_line(479);
    cyc(0, 1, 0, 489, 0);
    chk("wrap.de_vfp", de, 0);
    cyc(0, 1, 640, 489, 0); cyc(0, 1, 656, 489, 0); cyc(0, 1, 752, 489, 0);
    cyc(0, 1, 799, 489, 1);
    chk("wrap.vsync_on", vsync, 0);
    walk_line(491);
    chk("wrap.vsync_off", vsync, 1);
    walk_line(523);
    walk_line(524);
    cyc(0, 1, 0, 0, 0);
    chk("wrap.fstart", frame_start, 1);
    chk("wrap.lstart", line_start, 1);
    chk("wrap.vsync", vsync, 1);
    chk("wrap.de", de, 1);
    chk("wrap.desync", desync, 0);
    cyc(0, 1, 1, 0, 0);
    chk("wrap.fstart_end", frame_start, 0);
    chk("wrap.lstart_end", line_start, 0);

    // Randomized run: counter-like stimulus with jumps, stalls and resets.
    cyc(1, 0, 0, 0, 0);
    h = 0; v = 0;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom % 5) != 0;
      k = ($urandom % 200) == 0;
      if (($urandom % 100) == 0) begin
        h = $urandom % 850;
        v = $urandom % 600;
      end
      o = e && (h == 799);
      cyc(k, e, h, v, o);
      chk("rnd.de", de, m_de);
      chk("rnd.x", x, m_x);
      chk("rnd.y", y, m_y);
      chk("rnd.hsync", hsync, m_hs);
      chk("rnd.vsync", vsync, m_vs);
      chk("rnd.lstart", line_start, m_ls);
      chk("rnd.fstart", frame_start, m_fs);
      chk("rnd.desync", desync, m_ds);
      if (k) begin
        h = 0; v = 0;
      end else if (e) begin
        if (h >= 799) begin
          h = 0;
          v = (v >= 524) ? 0 : v + 1;
        end else begin
          h++;
        end
      end
    end

    // Full frame on a 28x15 timing: 20x10 active, 3-pixel hsync, 2-line vsync.
    en = 1'b0;
    s_clr = 1'b1; s_en = 1'b1;
    @(posedge c); #1;
    s_clr = 1'b0;
    n_de = 0; n_hs = 0; n_vs = 0; n_ds = 0;
    for (int vv = 0; vv < 15; vv++) begin
      for (int hh = 0; hh < 28; hh++) begin
        s_hc = 5'(hh); s_vc = 4'(vv); s_hovf = (hh == 27);
        @(posedge c); #1;
        if (s_de) n_de++;
        if (!s_hsync) n_hs++;
        if (!s_vsync) n_vs++;
        if (s_ds) n_ds++;
      end
    end
    chk("frame.de_cycles", n_de, 200);
    chk("frame.hsync_low", n_hs, 45);
    chk("frame.vsync_low", n_vs, 56);
    chk("frame.desync", n_ds, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
